// File: rtl/regfile_write_arbiter_if.sv
// Writeback request bundle: two requesters (A = ALU, B = load path) feeding the
// register file write arbiter over valid/ready handshakes.
interface regfile_write_arbiter_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
);
  logic              a_valid;
  logic              a_ready;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;

  // Requester side drives the writes and watches ready.
  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready
  );

  // Arbiter side accepts the writes and returns ready.
  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the single register file write port between two
// writeback requesters. The granted write sits in a one-entry stage that drives
// the write port; read ports bypass staged data ahead of its commit, and a
// saturating counter tracks cycles where both requesters contend.

// One read port's bypass: staged write data wins over the array read.
module regfile_write_arbiter_bypass #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic              rf_we,
  input  logic [ADDR_W-1:0] rf_waddr,
  input  logic [DATA_W-1:0] rf_wdata,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [DATA_W-1:0] rd_data
);
  // Register 0 is an ordinary register here, so no zero-address exception.
  always_comb begin
    rd_data = (rf_we && (rf_waddr == rd_addr)) ? rf_wdata : rf_rdata;
  end
endmodule

module regfile_write_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  regfile_write_arbiter_if.slave req,
  output logic                  rf_we,
  output logic [ADDR_W-1:0]     rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  input  logic [ADDR_W-1:0]     rd_addr1,
  input  logic [ADDR_W-1:0]     rd_addr2,
  input  logic [DATA_W-1:0]     rf_rdata1,
  input  logic [DATA_W-1:0]     rf_rdata2,
  output logic [DATA_W-1:0]     rd_data1,
  output logic [DATA_W-1:0]     rd_data2,
  output logic [CNT_W-1:0]      conflict_cnt
);
  localparam int NUM_RD = 2;

  typedef enum logic {PRI_A = 1'b0, PRI_B = 1'b1} pri_e;

  typedef struct packed {
    logic              vld;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } stage_t;

  pri_e              pri_q, pri_d;
  stage_t            stage_q, stage_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              a_go, b_go, both_vld;

  // Grant, stage load, priority rotation and contention count.
  // Ready looks only at the other requester's valid and the priority, never at
  // the stage, so a new write can be taken every cycle.
  always_comb begin
    both_vld    = req.a_valid && req.b_valid;
    req.a_ready = !req.b_valid || (pri_q == PRI_A);
    req.b_ready = !req.a_valid || (pri_q == PRI_B);
    a_go        = req.a_valid && req.a_ready;
    b_go        = req.b_valid && req.b_ready;
    pri_d       = pri_q;
    stage_d     = stage_q;
    stage_d.vld = 1'b0;
    if (a_go) begin
      stage_d = '{vld: 1'b1, addr: req.a_addr, data: req.a_data};
      pri_d   = PRI_B;
    end else if (b_go) begin
      stage_d = '{vld: 1'b1, addr: req.b_addr, data: req.b_data};
      pri_d   = PRI_A;
    end
    cnt_d = cnt_q;
    if (both_vld && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  // State registers; async reset drops any staged write before it commits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pri_q   <= PRI_A;
      stage_q <= '0;
      cnt_q   <= '0;
    end else begin
      pri_q   <= pri_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rf_we        = stage_q.vld;
  assign rf_waddr     = stage_q.addr;
  assign rf_wdata     = stage_q.data;
  assign conflict_cnt = cnt_q;

  logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr_v;
  logic [NUM_RD-1:0][DATA_W-1:0] rf_rdata_v, rd_data_v;

  assign rd_addr_v  = {rd_addr2, rd_addr1};
  assign rf_rdata_v = {rf_rdata2, rf_rdata1};
  assign rd_data1   = rd_data_v[0];
  assign rd_data2   = rd_data_v[1];

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    regfile_write_arbiter_bypass #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_byp (
      .rf_we    (stage_q.vld),
      .rf_waddr (stage_q.addr),
      .rf_wdata (stage_q.data),
      .rd_addr  (rd_addr_v[i]),
      .rf_rdata (rf_rdata_v[i]),
      .rd_data  (rd_data_v[i])
    );
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: reset, single requester, round-robin
// contention, bypass, async reset mid-write, counter saturation, B streaming and
// same-address ordering. Inputs change 1ns after the rising edge; outputs are
// sampled there too, well away from the edge.
module tb_regfile_write_arbiter;
  logic       clk;
  logic       rst_n;
  logic       rf_we;
  logic [2:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic [2:0] rd_addr1, rd_addr2;
  logic [7:0] rf_rdata1, rf_rdata2;
  logic [7:0] rd_data1, rd_data2;
  logic [7:0] conflict_cnt;
  int checks;
  int passed;

  regfile_write_arbiter_if #(.ADDR_W(3), .DATA_W(8)) wr ();

  regfile_write_arbiter #(.DATA_W(8), .ADDR_W(3), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (wr),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .rd_addr1     (rd_addr1),
    .rd_addr2     (rd_addr2),
    .rf_rdata1    (rf_rdata1),
    .rf_rdata2    (rf_rdata2),
    .rd_data1     (rd_data1),
    .rd_data2     (rd_data2),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr.a_valid = 0; wr.a_addr = 0; wr.a_data = 0;
    wr.b_valid = 0; wr.b_addr = 0; wr.b_data = 0;
  endtask

  task automatic pulse_reset();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rd_addr1 = 0; rd_addr2 = 0; rf_rdata1 = 0; rf_rdata2 = 0;
    rst_n = 0;
    #3;
    checks++; if (rf_we !== 1'b0) $display("FAIL reset_we got %b exp 0", rf_we); else passed++;
    checks++; if (rf_waddr !== 3'd0) $display("FAIL reset_waddr got %0d exp 0", rf_waddr); else passed++;
    checks++; if (rf_wdata !== 8'h00) $display("FAIL reset_wdata got %h exp 00", rf_wdata); else passed++;
    checks++; if (conflict_cnt !== 8'd0) $display("FAIL reset_cnt got %0d exp 0", conflict_cnt); else passed++;
    wr.a_valid = 1; wr.b_valid = 1;
    #1;
    checks++; if ({wr.a_ready, wr.b_ready} !== 2'b10) $display("FAIL reset_pri got %b exp 10", {wr.a_ready, wr.b_ready}); else passed++;
    idle_inputs();
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_a_only();
    wr.a_valid = 1; wr.a_addr = 3'd0; wr.a_data = 8'h0D;
    #1;
    checks++; if (wr.a_ready !== 1'b1) $display("FAIL aonly_ready got %b exp 1", wr.a_ready); else passed++;
    checks++; if (rf_we !== 1'b0) $display("FAIL aonly_pre_we got %b exp 0", rf_we); else passed++;
    tick();
    wr.a_valid = 0;
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 3'd0, 8'h0D}) $display("FAIL aonly_stage got %b/%0d/%h exp 1/0/0d", rf_we, rf_waddr, rf_wdata); else passed++;
    tick();
    checks++; if (rf_we !== 1'b0) $display("FAIL aonly_drop_we got %b exp 0", rf_we); else passed++;
    checks++; if ({rf_waddr, rf_wdata} !== {3'd0, 8'h0D}) $display("FAIL aonly_hold got %0d/%h exp 0/0d", rf_waddr, rf_wdata); else passed++;
  endtask

  // Both requesters present a fresh write every cycle; grants must alternate.
  task automatic test_round_robin();
    logic [1:0] exp_rdy [4];
    logic [2:0] exp_addr [4];
    logic [7:0] exp_data [4];
    exp_rdy  = '{2'b10, 2'b01, 2'b10, 2'b01};
    exp_addr = '{3'd1, 3'd2, 3'd1, 3'd2};
    exp_data = '{8'h03, 8'h0D, 8'h03, 8'h0D};
    pulse_reset();
    wr.a_valid = 1; wr.a_addr = 3'd1; wr.a_data = 8'h03;
    wr.b_valid = 1; wr.b_addr = 3'd2; wr.b_data = 8'h0D;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if ({wr.a_ready, wr.b_ready} !== exp_rdy[i]) $display("FAIL rr_grant%0d got %b exp %b", i, {wr.a_ready, wr.b_ready}, exp_rdy[i]); else passed++;
      tick();
      if (i == 3) begin wr.a_valid = 0; wr.b_valid = 0; end
      checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, exp_addr[i], exp_data[i]}) $display("FAIL rr_stage%0d got %b/%0d/%h exp 1/%0d/%h", i, rf_we, rf_waddr, rf_wdata, exp_addr[i], exp_data[i]); else passed++;
    end
    checks++; if (conflict_cnt !== 8'd4) $display("FAIL rr_cnt got %0d exp 4", conflict_cnt); else passed++;
  endtask

  // Runs while the stage still holds addr2/0x0D from the round-robin test.
  task automatic test_bypass();
    rd_addr1 = 3'd2; rf_rdata1 = 8'h00;
    rd_addr2 = 3'd1; rf_rdata2 = 8'h5A;
    #1;
    checks++; if (rd_data1 !== 8'h0D) $display("FAIL byp_hit got %h exp 0d", rd_data1); else passed++;
    checks++; if (rd_data2 !== 8'h5A) $display("FAIL byp_miss got %h exp 5a", rd_data2); else passed++;
    tick();
    checks++; if (rd_data1 !== 8'h00) $display("FAIL byp_nowe got %h exp 00", rd_data1); else passed++;
    rd_addr1 = 0; rd_addr2 = 0;
  endtask

  task automatic test_async_reset();
    // pri is A here (last grant went to B); both valid -> A granted, cnt 4 -> 5.
    wr.a_valid = 1; wr.a_addr = 3'd5; wr.a_data = 8'h77;
    wr.b_valid = 1; wr.b_addr = 3'd6; wr.b_data = 8'h66;
    tick();
    idle_inputs();
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 3'd5, 8'h77}) $display("FAIL arst_pre got %b/%0d/%h exp 1/5/77", rf_we, rf_waddr, rf_wdata); else passed++;
    checks++; if (conflict_cnt !== 8'd5) $display("FAIL arst_precnt got %0d exp 5", conflict_cnt); else passed++;
    #2;
    rst_n = 0;
    #1;
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 3'd0, 8'h00}) $display("FAIL arst_now got %b/%0d/%h exp 0/0/00", rf_we, rf_waddr, rf_wdata); else passed++;
    checks++; if (conflict_cnt !== 8'd0) $display("FAIL arst_cnt got %0d exp 0", conflict_cnt); else passed++;
    tick();
    rst_n = 1;
    tick();
    checks++; if (rf_we !== 1'b0) $display("FAIL arst_dropped got %b exp 0", rf_we); else passed++;
    wr.a_valid = 1; wr.b_valid = 1;
    #1;
    checks++; if ({wr.a_ready, wr.b_ready} !== 2'b10) $display("FAIL arst_pri got %b exp 10", {wr.a_ready, wr.b_ready}); else passed++;
    idle_inputs();
  endtask

  task automatic test_saturation();
    pulse_reset();
    wr.a_valid = 1; wr.b_valid = 1;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (i == 100) begin
        checks++; if (conflict_cnt !== 8'd100) $display("FAIL sat_100 got %0d exp 100", conflict_cnt); else passed++;
      end
      if (i == 255) begin
        checks++; if (conflict_cnt !== 8'd255) $display("FAIL sat_255 got %0d exp 255", conflict_cnt); else passed++;
      end
    end
    checks++; if (conflict_cnt !== 8'd255) $display("FAIL sat_300 got %0d exp 255", conflict_cnt); else passed++;
    checks++; if (rf_we !== 1'b1) $display("FAIL sat_we got %b exp 1", rf_we); else passed++;
    idle_inputs();
    tick();
    checks++; if (conflict_cnt !== 8'd255) $display("FAIL sat_hold got %0d exp 255", conflict_cnt); else passed++;
  endtask

  task automatic test_back_to_back();
    wr.b_valid = 1;
    for (int i = 0; i < 4; i++) begin
      wr.b_addr = 3'(4 + i);
      wr.b_data = 8'(8'h40 + i);
      #1;
      checks++; if (wr.b_ready !== 1'b1) $display("FAIL b2b_ready%0d got %b exp 1", i, wr.b_ready); else passed++;
      tick();
      checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 3'(4 + i), 8'(8'h40 + i)}) $display("FAIL b2b_stage%0d got %b/%0d/%h exp 1/%0d/%h", i, rf_we, rf_waddr, rf_wdata, 4 + i, 8'h40 + i); else passed++;
    end
    idle_inputs();
    tick();
    checks++; if (rf_we !== 1'b0) $display("FAIL b2b_end got %b exp 0", rf_we); else passed++;
  endtask

  // Last grant was B, so A goes first; the two writes to r3 issue in grant order.
  task automatic test_same_addr();
    wr.a_valid = 1; wr.a_addr = 3'd3; wr.a_data = 8'h11;
    wr.b_valid = 1; wr.b_addr = 3'd3; wr.b_data = 8'h22;
    tick();
    wr.a_valid = 0;
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 3'd3, 8'h11}) $display("FAIL same_first got %b/%0d/%h exp 1/3/11", rf_we, rf_waddr, rf_wdata); else passed++;
    tick();
    idle_inputs();
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 3'd3, 8'h22}) $display("FAIL same_second got %b/%0d/%h exp 1/3/22", rf_we, rf_waddr, rf_wdata); else passed++;
    tick();
  endtask

  initial begin
    checks = 0;
    passed = 0;
    test_reset();
    test_a_only();
    test_round_robin();
    test_bypass();
    test_async_reset();
    test_saturation();
    test_back_to_back();
    test_same_addr();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
